// File: rtl/md_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package md_pkg;

  // Operation codes as issued by the control unit.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  localparam int MD_DEF_WIDTH = 32;

  // Iteration counter width for a given operand width.
  function automatic int md_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // MULT and DIV work on magnitudes; MULTU/DIVU use raw operands.
  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide unit with the HI/LO register pair.
//
// Handshake: start is taken on a rising edge only while busy is low; there is
// no separate ready, ~busy is the ready. A multiply/divide keeps busy high for
// WIDTH+1 cycles and then pulses done for one cycle as hi/lo update. MTHI/MTLO
// update hi/lo one edge after start and never raise busy or done. The state
// output is the sequencer state, exposed for observation only.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output md_state_e        state
);

  localparam int CNT_W = md_cnt_w(WIDTH);

  md_state_e          state_n;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;        // shared shift register: {upper, lower}
  logic [WIDTH-1:0]   opb;        // multiplicand or divisor magnitude
  logic               neg_q;      // negate product / quotient in FIX
  logic               neg_r;      // negate remainder in FIX
  logic               was_div;    // FIX finishes a divide rather than a multiply

  logic               ld_mul, ld_div, wr_hi, wr_lo, last_iter;
  logic               sgn;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum, div_part, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign sgn  = md_is_signed(md_op);
  assign mag1 = (sgn && num1[WIDTH-1]) ? -num1 : num1;
  assign mag2 = (sgn && num2[WIDTH-1]) ? -num2 : num2;

  assign busy      = (state != ST_IDLE);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // One iteration of shift-add multiply and restoring divide, plus sign fix.
  always_comb begin
    // Multiply: add multiplicand when the multiplier LSB is set, then shift right.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    // Divide: shift the next dividend bit into a WIDTH+1-bit partial remainder
    // and subtract the divisor if it fits. A zero divisor always "fits", which
    // yields an all-ones quotient and leaves the dividend as the remainder.
    div_part = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_part - {1'b0, opb};
    div_ge   = (div_part >= {1'b0, opb});
    div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0]),
                acc[WIDTH-2:0], div_ge};
    // Sign correction applied at FIX.
    prod_fix = neg_q ? -acc : acc;
    q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state and launch/write decode.
  always_comb begin
    state_n = state;
    ld_mul  = 1'b0;
    ld_div  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin state_n = ST_MUL; ld_mul = 1'b1; end
            MD_DIV, MD_DIVU:   begin state_n = ST_DIV; ld_div = 1'b1; end
            MD_MTHI:           wr_hi = 1'b1;
            MD_MTLO:           wr_lo = 1'b1;
            default:           ;  // reserved codes do nothing
          endcase
        end
      end
      ST_MUL:  if (last_iter) state_n = ST_FIX;
      ST_DIV:  if (last_iter) state_n = ST_FIX;
      ST_FIX:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      opb     <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      was_div <= 1'b0;
    end else if (ld_mul) begin
      acc     <= {{WIDTH{1'b0}}, mag2};
      opb     <= mag1;
      cnt     <= '0;
      neg_q   <= sgn & (num1[WIDTH-1] ^ num2[WIDTH-1]);
      neg_r   <= 1'b0;
      was_div <= 1'b0;
    end else if (ld_div) begin
      acc     <= {{WIDTH{1'b0}}, mag1};
      opb     <= mag2;
      cnt     <= '0;
      // No quotient negation on divide-by-zero so lo stays all ones; the
      // remainder negation restores num1 exactly in hi.
      neg_q   <= sgn & (num1[WIDTH-1] ^ num2[WIDTH-1]) & (num2 != '0);
      neg_r   <= sgn & num1[WIDTH-1];
      was_div <= 1'b1;
    end else if (state == ST_MUL) begin
      acc <= mul_next;
      cnt <= cnt + CNT_W'(1);
    end else if (state == ST_DIV) begin
      acc <= div_next;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // HI/LO registers and the completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == ST_FIX);
      if (state == ST_FIX) begin
        if (was_div) begin
          hi <= r_fix;
          lo <= q_fix;
        end else begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end
      end else begin
        if (wr_hi) hi <= num1;
        if (wr_lo) lo <= num1;
      end
    end
  end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit holding the HI/LO register pair for the MIPS core. It sits beside the ALU, downstream of `reg_heap`. It consumes the register-read operands `rd1` (rs) and `rd2` (rt) and an operation code from `cu`, and produces HI/LO for MFHI/MFLO write-back. Each multiply or divide takes a fixed WIDTH+1 cycles, and `busy` stalls the PC while an operation is in progress.

## Interface
- `WIDTH`, default 32: operand width; also the iteration count.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: launches the operation in `md_op`; sampled only when `busy`=0.
- `md_op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved (ignored).
- `num1` in WIDTH: rs operand (multiplicand or dividend; MTHI/MTLO source).
- `num2` in WIDTH: rt operand (multiplier or divisor).
- `busy` out 1: a multiply or divide is in flight; the core holds the PC while it is high.
- `done` out 1: one-cycle pulse; HI/LO just received a new multiply/divide result.
- `hi` out WIDTH: HI register (product upper half, or remainder).
- `lo` out WIDTH: LO register (product lower half, or quotient).

## Operation
- **States:** IDLE, MUL, DIV, FIX.
  - IDLE, `start` & op 0/1 → MUL.
  - IDLE, `start` & op 2/3 → DIV.
  - MUL/DIV → FIX after WIDTH iterations.
  - FIX → IDLE.
- **Operand capture:** at the start edge, the unit latches |num1|, |num2| and the result signs.
  - Signed ops (MULT/DIV) use magnitudes; the unsigned variants use the raw values.
  - Sign capture: multiply result sign = sign(num1) XOR sign(num2); quotient sign likewise; remainder sign = sign(num1).
- **MUL:** radix-2 shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
- **DIV:** restoring division with a WIDTH+1-bit partial remainder, one quotient bit per cycle.
- **FIX:** applies two's-complement negation per the captured signs, then writes `{hi,lo}` and pulses `done`.
- **Divide by zero (DIV and DIVU):** lo = all ones, hi = num1. No sign fix is applied.
- **DIV 0x80000000 / −1:** lo = 0x80000000, hi = 0. This is the natural wrap; no trap is raised.
- **MTHI/MTLO:** accepted only in IDLE. Writes `num1` into hi/lo at the start edge. No `busy`, no `done`.
- **Start while busy:** ignored; `md_op` and operands are not re-sampled. The core must stall.
- **Reserved ops:** no state change.
- **hi/lo during an operation:** hold their previous values until the FIX edge. An MFHI/MFLO issued while `busy` is high returns the old values; the core stalls MF* on `busy`.

## Timing
- **Reset:** state IDLE, hi=0, lo=0, busy=0, done=0, internal accumulators 0.
- **Reset mid-operation:** aborts immediately (asynchronous). The result is discarded and hi/lo are cleared.
- **Multiply/divide cycle count:** start sampled at edge k.
  - `busy`=1 from after edge k through edge k+WIDTH+1.
  - Iterations occupy edges k+1 … k+WIDTH.
  - FIX writes hi/lo at edge k+WIDTH+1; `busy` falls and `done`=1 for exactly the following cycle.
  - `busy` is high for WIDTH+1 cycles; hi/lo are valid WIDTH+1 cycles after the start edge.
- **Back-to-back:** a new `start` is accepted in the same cycle `done` is high. The write-back of the previous result is not lost.
- **MTHI/MTLO latency:** 1 edge. They may be issued in the cycle `done` is high.
- **Outputs:** `busy`, `done`, `hi`, `lo` are all registered; no combinational path from inputs to outputs.

## Structure
- **Package `md_pkg`:**
  - `md_op` encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - State encoding.
  - Iteration counter width `$clog2(WIDTH+1)`.
- **Datapath:** a single module with one shared 2·WIDTH shift register used by both multiply and divide.
- **Sub-modules:** none needed. The iteration logic is small enough to stay inline.
- **Core integration:** `cu` gains `cu_md_start` and `cu_md_op`; write-back gains hi/lo sources; `busy` gates the PC enable.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, `done` high exactly 1 cycle, `busy` high 33 cycles.
- MULT −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 0 → lo=0xFFFFFFFF, hi=7. DIV 0x80000000 / −1 → lo=0x80000000, hi=0.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → hi=0x1234, lo=0x5678 one edge after each; `busy` stays 0.
- MULTU 3×4 started, then `start` with DIVU 9/2 at cycle 5 → second start ignored; result is hi=0, lo=12. DIVU issued in the `done` cycle → lo=4, hi=1 after 33 more cycles.
- Assert `rst_n`=0 at cycle 10 of a DIVU → `busy`, `done`, hi, lo all 0 immediately. A following MULTU 6×7 → lo=42, hi=0.
